// File: rtl/rikshaw_throttle_driver_if.sv
// Control/status bundle between the HPS-facing control block and the throttle driver.
//   enable        : throttle enable level
//   target_duty   : requested duty in PWM counts
//   target_valid  : one-cycle strobe latching target_duty and kicking the watchdog
//   emergency_off : level, high forces an immediate stop
//   pwm_o         : registered PWM output to the motor controller
//   current_duty  : duty currently being ramped
//   state_o       : 0=IDLE 1=RAMP 2=HOLD 3=ESTOP
//   fault         : watchdog expired, sticky until the next target_valid
interface rikshaw_throttle_driver_if;
  logic        enable;
  logic [15:0] target_duty;
  logic        target_valid;
  logic        emergency_off;
  logic        pwm_o;
  logic [15:0] current_duty;
  logic [1:0]  state_o;
  logic        fault;

  modport master (
    output enable, target_duty, target_valid, emergency_off,
    input  pwm_o, current_duty, state_o, fault
  );

  modport slave (
    input  enable, target_duty, target_valid, emergency_off,
    output pwm_o, current_duty, state_o, fault
  );
endinterface

// File: rtl/rikshaw_throttle_driver.sv
// Throttle driver: turns an enable level and a duty request into a slew-limited PWM
// output, with emergency stop and a command watchdog so a stale setpoint is never held.
// Ports:
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   bus     : control/status bundle (slave side), see rikshaw_throttle_driver_if
module rikshaw_throttle_driver #(
  parameter int unsigned CLOCK_SPEED_HZ = 50_000_000,
  parameter int unsigned PWM_FREQ_HZ    = 20_000,
  parameter int unsigned RAMP_TICK_HZ   = 1_000,
  parameter int unsigned RAMP_STEP      = 1,
  parameter int unsigned WATCHDOG_MS    = 500
) (
  input  logic                       clock,
  input  logic                       reset_n,
  rikshaw_throttle_driver_if.slave   bus
);

  localparam int unsigned PERIOD_I = CLOCK_SPEED_HZ / PWM_FREQ_HZ;
  localparam int unsigned TICK_I   = CLOCK_SPEED_HZ / RAMP_TICK_HZ;
  localparam int unsigned MS_RAW   = CLOCK_SPEED_HZ / 1000;
  localparam int unsigned MS_I     = (MS_RAW == 0) ? 1 : MS_RAW;

  localparam logic [15:0] PERIOD      = PERIOD_I[15:0];
  localparam logic [15:0] PERIOD_LAST = PERIOD - 16'd1;
  localparam logic [15:0] STEP        = RAMP_STEP[15:0];
  localparam logic [31:0] TICK_LAST   = TICK_I - 32'd1;
  localparam logic [31:0] MS_LAST     = MS_I - 32'd1;
  localparam logic [31:0] WD_LIMIT    = WATCHDOG_MS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    HOLD  = 2'd2,
    ESTOP = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [15:0] pwm_cnt;
  logic [15:0] applied_duty;
  logic [15:0] cur_duty;
  logic [15:0] target;
  logic [15:0] target_clamped;
  logic [15:0] eff_target;
  logic [15:0] duty_step;
  logic [31:0] tick_cnt;
  logic [31:0] ms_cnt;
  logic [31:0] wd_cnt;
  logic        fault_r;
  logic        pwm_r;
  logic        tick_wrap;
  logic        pwm_wrap;
  logic        ms_wrap;
  logic        estop_hit;

  assign tick_wrap      = (tick_cnt == TICK_LAST);
  assign pwm_wrap       = (pwm_cnt == PERIOD_LAST);
  assign ms_wrap        = (ms_cnt == MS_LAST);
  // Entering ESTOP and sitting in it both force the output path to zero.
  assign estop_hit      = bus.emergency_off || (state == ESTOP);
  assign target_clamped = (bus.target_duty > PERIOD) ? PERIOD : bus.target_duty;
  assign eff_target     = (!bus.enable || fault_r) ? '0 : target;

  // One slew step toward the effective target, landing exactly on it when close.
  always_comb begin
    duty_step = cur_duty;
    if (eff_target > cur_duty) begin
      duty_step = ((eff_target - cur_duty) <= STEP) ? eff_target : cur_duty + STEP;
    end else if (eff_target < cur_duty) begin
      duty_step = ((cur_duty - eff_target) <= STEP) ? eff_target : cur_duty - STEP;
    end
  end

  always_comb begin
    state_n = state;
    if (bus.emergency_off) begin
      state_n = ESTOP;
    end else begin
      case (state)
        IDLE:    if (eff_target != '0) state_n = RAMP;
        RAMP:    if (cur_duty == eff_target) state_n = (eff_target == '0) ? IDLE : HOLD;
        HOLD:    if (eff_target != cur_duty) state_n = RAMP;
        ESTOP:   if (!bus.enable) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      pwm_cnt  <= pwm_wrap ? '0 : pwm_cnt + 16'd1;
      tick_cnt <= tick_wrap ? '0 : tick_cnt + 32'd1;
    end
  end

  // Target and duty path. A strobe coinciding with a ramp tick only updates
  // target, so that tick still steps toward the previous value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      target       <= '0;
      cur_duty     <= '0;
      applied_duty <= '0;
      pwm_r        <= 1'b0;
    end else if (estop_hit) begin
      target       <= '0;
      cur_duty     <= '0;
      applied_duty <= '0;
      pwm_r        <= 1'b0;
    end else begin
      if (bus.target_valid) target <= target_clamped;
      if (tick_wrap) cur_duty <= duty_step;
      if (pwm_wrap) applied_duty <= cur_duty;
      pwm_r <= (pwm_cnt < applied_duty);
    end
  end

  // Watchdog: millisecond prescaler plus saturating ms counter. The strobe branch
  // comes first so it wins over a same-cycle expiry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ms_cnt  <= '0;
      wd_cnt  <= '0;
      fault_r <= 1'b0;
    end else if (bus.target_valid) begin
      ms_cnt  <= '0;
      wd_cnt  <= '0;
      fault_r <= 1'b0;
    end else if (!bus.enable) begin
      ms_cnt <= '0;
      wd_cnt <= '0;
    end else if (state != ESTOP) begin
      if (ms_wrap) begin
        ms_cnt <= '0;
        if (wd_cnt != WD_LIMIT) begin
          wd_cnt <= wd_cnt + 32'd1;
          if (wd_cnt == WD_LIMIT - 32'd1) fault_r <= 1'b1;
        end
      end else begin
        ms_cnt <= ms_cnt + 32'd1;
      end
    end
  end

  assign bus.pwm_o        = pwm_r;
  assign bus.current_duty = cur_duty;
  assign bus.state_o      = state;
  assign bus.fault        = fault_r;

endmodule
